// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit,
// delivered through a one-entry valid/ready buffer. Parity enabled by SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   input  logic             bit_en,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] asm_r;

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic par_r;

   // Even parity: data bits plus parity bit must XOR to zero.
   function automatic logic parity_ok(input logic [WIDTH-1:0] d, input logic p);
      return ~(^{d, p});
   endfunction
`endif

   // Frame FSM, assembly register and registered output buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         asm_r      <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_r      <= 1'b0;
`endif
         data_out   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;

         // A consume clears the buffer; a good word loading below overrides it.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (bit_en) begin
            case (state_r)
               IDLE: begin
                  if (!serial_in) begin
                     state_r <= DATA;
                     cnt_r   <= '0;
                     busy    <= 1'b1;
                  end
               end
               DATA: begin
                  asm_r <= {serial_in, asm_r[WIDTH-1:1]};
                  cnt_r <= cnt_r + CNT_ONE;
                  if (cnt_r == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                     state_r <= PARITY;
`else
                     state_r <= STOP;
`endif
                  end
               end
               PARITY: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  par_r <= serial_in;
`endif
                  state_r <= STOP;
               end
               STOP: begin
                  // A 0 stop sample is not treated as the next start bit.
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  if (!serial_in) begin
                     frame_err <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  end else if (!parity_ok(asm_r, par_r)) begin
                     parity_err <= 1'b1;
`endif
                  end else if (!out_valid || out_ready) begin
                     data_out  <= asm_r;
                     out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8): a vector table of whole frames plus
// hand-written sequences for reset, back-to-back/overrun and bit_en gaps.
module tb_serial_frame_rx;

   localparam int W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         serial_in = 1'b1;
   logic         bit_en = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] data_out;
   logic         out_valid;
   logic         busy;
   logic         frame_err;
   logic         parity_err;
   logic         overrun;

   int n_vec = 0;
   int n_err = 0;

   serial_frame_rx #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .bit_en     (bit_en),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       bad_par;
      int         gap;
      logic       ready;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
      logic       exp_perr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe preceded by gap-1 idle clocks; returns 1 time unit after the sampling edge.
   task automatic strobe(input logic b, input int gap);
      repeat (gap - 1) tick();
      serial_in = b;
      bit_en    = 1'b1;
      tick();
      bit_en    = 1'b0;
      serial_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                             input int gap, input logic stop_ready, input int pause_at);
      strobe(1'b0, gap);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < W; i++) begin
         strobe(d[i], gap);
         if (i == pause_at) begin
            repeat (50) tick();
            chk("busy_in_pause", {31'd0, busy}, 32'd1);
         end
      end
      if (PAR_EN) strobe((^d) ^ bad_par, gap);
      if (stop_ready) out_ready = 1'b1;
      strobe(stop, gap);
      if (stop_ready) out_ready = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic fe, input logic pe, input logic ov);
      chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
      chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, fe});
      chk({tag, "_parity_err"}, {31'd0, parity_err}, {31'd0, pe});
      chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ov});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      //          data   stop  badp  gap ready valid edata  ferr perr ovr
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hC3, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'h07, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};

      #12;
      chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 7; k++) begin
         logic perr_exp;
         perr_exp = vecs[k].bad_par & PAR_EN;
         out_ready = vecs[k].ready;
         send_frame(vecs[k].data, vecs[k].stop, vecs[k].bad_par, vecs[k].gap, 1'b0, -1);
         chk_out($sformatf("vec%0d", k), vecs[k].exp_valid & ~perr_exp, vecs[k].exp_data,
                 vecs[k].exp_ferr, perr_exp, vecs[k].exp_ovr);
      end
      if (PAR_EN) begin
         tick();
         chk("parity_err_one_cycle", {31'd0, parity_err}, 32'd0);
      end

      // Back-to-back with the buffer held full: second word overruns.
      drain();
      send_frame(8'h11, 1'b1, 1'b0, 1, 1'b0, -1);
      chk_out("b2b_first", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1, 1'b0, -1);
      chk_out("b2b_overrun", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
      tick();
      chk("overrun_one_cycle", {31'd0, overrun}, 32'd0);

      // Same, with out_ready pulsed on the stop strobe of the second frame.
      drain();
      send_frame(8'h11, 1'b1, 1'b0, 1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, 1, 1'b1, -1);
      chk_out("b2b_consume", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-DATA with a word pending.
      drain();
      send_frame(8'h5A, 1'b1, 1'b0, 1, 1'b0, -1);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      strobe(1'b0, 1);
      strobe(1'b1, 1);
      strobe(1'b0, 1);
      strobe(1'b1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      send_frame(8'h96, 1'b1, 1'b0, 2, 1'b0, -1);
      chk_out("post_reset", 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);

      // 50-clock bit_en gap in the middle of DATA.
      send_frame(8'h4B, 1'b1, 1'b0, 1, 1'b0, 3);
      chk_out("bit_en_gap", 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
